// File: rtl/ds1302_disp_fmt.sv
// Formats captured DS1302 BCD time/date bytes into eight registered display codes.
// Optional DISP_LEADING_ZERO_BLANK_EN blanks leading-zero hour/month/day tens digits.
module ds1302_disp_fmt #(
   parameter logic [15:0] CNT_1MS_MAX = 16'd49_999,
   parameter logic [15:0] PAGE_MS     = 16'd5000,
   parameter logic [15:0] STALE_MS    = 16'd2000
) (
   input  logic       sclk,
   input  logic       rst,
   input  logic       data_vld,
   input  logic [7:0] sec,
   input  logic [7:0] min,
   input  logic [7:0] hour,
   input  logic [7:0] date,
   input  logic [7:0] month,
   input  logic [7:0] year,
   input  logic       page_hold,
   output logic [3:0] bit_7,
   output logic [3:0] bit_6,
   output logic [3:0] bit_5,
   output logic [3:0] bit_4,
   output logic [3:0] bit_3,
   output logic [3:0] bit_2,
   output logic [3:0] bit_1,
   output logic [3:0] bit_0,
   output logic       page,
   output logic       stale
);

   localparam logic [3:0] BLANK = 4'd10;
   localparam logic [3:0] DASH  = 4'd11;

   logic [15:0]     cnt_1ms, cnt_page, cnt_stale;
   logic [7:0]      sec_q, min_q, hour_q, date_q, month_q, year_q;
   logic [7:0][3:0] disp, nxt;
   logic            tick, stale_now;

   assign tick      = (cnt_1ms == CNT_1MS_MAX);
   assign stale_now = (cnt_stale == STALE_MS);

   function automatic logic [3:0] dig(input logic [3:0] n);
      return (n > 4'd9) ? BLANK : n;
   endfunction

   // Leading-zero suppression only applies to tens digits that can legitimately be 0.
   function automatic logic [3:0] lz(input logic [3:0] d);
`ifdef DISP_LEADING_ZERO_BLANK_EN
      return (d == 4'd0) ? BLANK : d;
`else
      return d;
`endif
   endfunction

   always_comb begin
      nxt = {8{DASH}};
      if (!stale_now) begin
         if (!page) begin
            nxt[7] = lz(dig({2'b00, hour_q[5:4]}));
            nxt[6] = dig(hour_q[3:0]);
            nxt[4] = dig({1'b0, min_q[6:4]});
            nxt[3] = dig(min_q[3:0]);
            nxt[1] = dig({1'b0, sec_q[6:4]});
            nxt[0] = dig(sec_q[3:0]);
         end else begin
            nxt[7] = dig(year_q[7:4]);
            nxt[6] = dig(year_q[3:0]);
            nxt[4] = lz(dig({3'b000, month_q[4]}));
            nxt[3] = dig(month_q[3:0]);
            nxt[1] = lz(dig({2'b00, date_q[5:4]}));
            nxt[0] = dig(date_q[3:0]);
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         cnt_1ms   <= '0;
         cnt_page  <= '0;
         cnt_stale <= STALE_MS;
         page      <= 1'b0;
         stale     <= 1'b1;
         sec_q     <= '0;
         min_q     <= '0;
         hour_q    <= '0;
         date_q    <= '0;
         month_q   <= '0;
         year_q    <= '0;
         disp      <= {8{DASH}};
      end else begin
         cnt_1ms <= tick ? 16'd0 : cnt_1ms + 16'd1;

         if (data_vld) begin
            sec_q   <= sec;
            min_q   <= min;
            hour_q  <= hour;
            date_q  <= date;
            month_q <= month;
            year_q  <= year;
         end

         // A fresh strobe wins over a tick landing in the same cycle.
         if (data_vld)
            cnt_stale <= '0;
         else if (tick && !stale_now)
            cnt_stale <= cnt_stale + 16'd1;

         if (tick && !page_hold) begin
            if (cnt_page == PAGE_MS - 16'd1) begin
               cnt_page <= '0;
               page     <= ~page;
            end else begin
               cnt_page <= cnt_page + 16'd1;
            end
         end

         stale <= stale_now;
         disp  <= nxt;
      end
   end

   assign {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0} = disp;

endmodule

// File: tb/tb_ds1302_disp_fmt.sv
// Directed, table-driven bench for ds1302_disp_fmt with short ms/page/stale timers.
module tb_ds1302_disp_fmt;

   logic       sclk = 1'b0;
   logic       rst, data_vld, page_hold;
   logic [7:0] sec, min, hour, date, month, year;
   logic [3:0] bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
   logic       page, stale;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sclk = ~sclk;

   ds1302_disp_fmt #(
      .CNT_1MS_MAX(16'd9), .PAGE_MS(16'd4), .STALE_MS(16'd3)
   ) dut (
      .sclk(sclk), .rst(rst), .data_vld(data_vld),
      .sec(sec), .min(min), .hour(hour), .date(date), .month(month), .year(year),
      .page_hold(page_hold),
      .bit_7(bit_7), .bit_6(bit_6), .bit_5(bit_5), .bit_4(bit_4),
      .bit_3(bit_3), .bit_2(bit_2), .bit_1(bit_1), .bit_0(bit_0),
      .page(page), .stale(stale)
   );

   typedef struct {
      logic [7:0]  hr, mn, sc, yr, mo, dt;
      logic [31:0] tdig;   // time page codes, bit_7 in [31:28]
      logic [31:0] ddig;   // date page codes
   } vec_t;

   vec_t vecs[6];

   localparam logic [31:0] DASHES = 32'hbbbb_bbbb;

   function automatic logic [31:0] adj_time(input logic [31:0] e);
      logic [31:0] r;
      r = e;
`ifdef DISP_LEADING_ZERO_BLANK_EN
      if (r[31:28] == 4'd0) r[31:28] = 4'd10;
`endif
      return r;
   endfunction

   function automatic logic [31:0] adj_date(input logic [31:0] e);
      logic [31:0] r;
      r = e;
`ifdef DISP_LEADING_ZERO_BLANK_EN
      if (r[19:16] == 4'd0) r[19:16] = 4'd10;
      if (r[7:4] == 4'd0)   r[7:4]   = 4'd10;
`endif
      return r;
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sclk);
         #1;
      end
   endtask

   // Runs n edges, optionally pulsing data_vld every 8th edge to keep data fresh.
   task automatic run(input int n, input bit keep);
      for (int i = 0; i < n; i++) begin
         data_vld = keep && (i % 8 == 0);
         @(posedge sclk);
         #1;
      end
      data_vld = 1'b0;
   endtask

   task automatic chk_disp(input string name, input logic [31:0] exp);
      logic [31:0] act;
      act = {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: digits got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic wait_page(input logic v);
      int k;
      k = 0;
      while (page !== v && k < 100) begin
         data_vld = (k % 8 == 0);
         @(posedge sclk);
         #1;
         k++;
      end
      data_vld = 1'b0;
      chk_bit("wait_page", page, v);
   endtask

   task automatic load(input vec_t v);
      hour = v.hr; min = v.mn; sec = v.sc;
      year = v.yr; month = v.mo; date = v.dt;
   endtask

   initial begin
      vecs[0] = '{8'h23, 8'h59, 8'hB7, 8'h24, 8'h12, 8'h31, 32'h23b5_9b37, 32'h24b1_2b31};
      vecs[1] = '{8'h23, 8'h5C, 8'hB7, 8'hA4, 8'h1F, 8'h3B, 32'h23b5_ab37, 32'ha4b1_ab3a};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 32'h00b0_0b00, 32'h00b0_1b01};
      vecs[3] = '{8'h3F, 8'hFA, 8'h80, 8'h99, 8'hE9, 8'hC5, 32'h3ab7_ab00, 32'h99b0_9b05};
      vecs[4] = '{8'h07, 8'h05, 8'h07, 8'h50, 8'h10, 8'h20, 32'h07b0_5b07, 32'h50b1_0b20};
      vecs[5] = '{8'hC9, 8'h9A, 8'h45, 8'h07, 8'h09, 8'h09, 32'h09b1_ab45, 32'h07b0_9b09};

      rst = 1'b1; data_vld = 1'b0; page_hold = 1'b0;
      sec = '0; min = '0; hour = '0; date = '0; month = '0; year = '0;
      step(3);
      rst = 1'b0;
      chk_disp("reset_digits", DASHES);
      chk_bit("reset_stale", stale, 1'b1);
      chk_bit("reset_page", page, 1'b0);
      step(1);
      chk_disp("idle_digits", DASHES);
      chk_bit("idle_stale", stale, 1'b1);

      // First capture: visible two edges after the strobe is applied.
      load(vecs[0]);
      data_vld = 1'b1;
      step(1);
      data_vld = 1'b0;
      chk_bit("latency_stale_still", stale, 1'b1);
      chk_disp("latency_dash_still", DASHES);
      step(1);
      chk_disp("first_time", vecs[0].tdig);
      chk_bit("first_stale", stale, 1'b0);

      // Page toggles on the 4th tick (edge 40 after reset).
      run(36, 1'b1);
      chk_bit("page_before_toggle", page, 1'b0);
      step(1);
      chk_bit("page_toggled", page, 1'b1);
      chk_disp("digits_lag_toggle", vecs[0].tdig);
      chk_bit("stale_kept_fresh", stale, 1'b0);
      step(1);
      chk_disp("date_page", vecs[0].ddig);

      // Three ticks without data: stale at the third, dashes one edge later.
      step(19);
      chk_bit("stale_not_yet", stale, 1'b0);
      step(1);
      chk_bit("stale_set", stale, 1'b1);
      chk_disp("stale_dashes", DASHES);
      data_vld = 1'b1;
      step(1);
      data_vld = 1'b0;
      chk_disp("restore_lag", DASHES);
      step(1);
      chk_bit("stale_cleared", stale, 1'b0);
      chk_disp("restore_date", vecs[0].ddig);

      // Hold across 10 ticks, then resume from the frozen count (2 of 4).
      page_hold = 1'b1;
      run(100, 1'b1);
      chk_bit("hold_page", page, 1'b1);
      page_hold = 1'b0;
      step(16);
      chk_bit("resume_page_before", page, 1'b1);
      step(1);
      chk_bit("resume_page_toggled", page, 1'b0);
      step(1);
      chk_disp("resume_time", vecs[0].tdig);

      for (int i = 0; i < 6; i++) begin
         load(vecs[i]);
         data_vld = 1'b1;
         step(1);
         data_vld = 1'b0;
         step(1);
         chk_disp($sformatf("time_vec%0d", i), adj_time(vecs[i].tdig));
         chk_bit($sformatf("time_vec%0d_page", i), page, 1'b0);
      end

      wait_page(1'b1);
      for (int i = 0; i < 6; i++) begin
         load(vecs[i]);
         data_vld = 1'b1;
         step(1);
         data_vld = 1'b0;
         step(1);
         chk_disp($sformatf("date_vec%0d", i), adj_date(vecs[i].ddig));
         chk_bit($sformatf("date_vec%0d_page", i), page, 1'b1);
      end

      // New data on the same edge as the page toggle shows on the new page.
      step(27);
      chk_bit("simul_page_before", page, 1'b1);
      hour = 8'h12; min = 8'h34; sec = 8'h56;
      data_vld = 1'b1;
      step(1);
      data_vld = 1'b0;
      chk_bit("simul_page_toggled", page, 1'b0);
      step(1);
      chk_disp("simul_time", 32'h12b3_4b56);
      chk_bit("simul_stale", stale, 1'b0);

      // Mid-operation reset from the date page.
      wait_page(1'b1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk_disp("midrst_digits", DASHES);
      chk_bit("midrst_stale", stale, 1'b1);
      chk_bit("midrst_page", page, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
